reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Next-gen pipeline register file: parametrised width/depth, hardwired zero register,
//  write-to-read bypass, per-register pending (scoreboard) bits for hazard detection, and
//  a post-reset clearing sweep so every register reads 0 after reset.
//  Sits between decode (reads, reservations) and writeback (writes) in the mini-Processor pipeline.
// PARAMETERS
//  DATA_WIDTH  64  register width in bits
//  ADDR_WIDTH  4   address width; DEPTH = 1<<ADDR_WIDTH registers
//  BYPASS      1   1: same-cycle write data forwarded to read ports; 0: write visible next cycle
// PORTS
//  clk        in   1           clock, all state on rising edge
//  rst        in   1           synchronous, active-high reset
//  ready      out  1           1 = clearing sweep done, port accepts ops
//  wena       in   1           write enable (writeback)
//  waddr      in   ADDR_WIDTH  write address
//  wdata      in   DATA_WIDTH  write data
//  resv_en    in   1           reserve: mark resv_addr pending (decode issue of a writer)
//  resv_addr  in   ADDR_WIDTH  register to reserve
//  r0addr     in   ADDR_WIDTH  read port 0 address
//  r1addr     in   ADDR_WIDTH  read port 1 address
//  r0data     out  DATA_WIDTH  read port 0 data (combinational)
//  r1data     out  DATA_WIDTH  read port 1 data (combinational)
//  r0busy     out  1           r0addr has a pending write
//  r1busy     out  1           r1addr has a pending write
// BEHAVIOUR
//  - FSM states: INIT (sweep), RUN. rst=1 -> state INIT, idx<=1, all pending bits<=0.
//  - INIT: each cycle regFile[idx]<=0, idx++; when idx==DEPTH-1 written -> RUN. Lasts DEPTH-1
//    cycles after rst falls; ready=0 in INIT, 1 in RUN. wena/resv_en ignored in INIT;
//    r*data=0 and r*busy=0 in INIT.
//  - rst asserted mid-sweep or in RUN: restart INIT next edge; registers re-cleared, pending cleared.
//  - Outputs under rst/INIT: ready=0, r0data=r1data=0, r0busy=r1busy=0.
//  - Register 0: never stored; reads return 0, busy=0; writes and reservations to 0 are dropped.
//  - Write (RUN): wena && waddr!=0 -> regFile[waddr]<=wdata, pending[waddr]<=0.
//  - Reserve (RUN): resv_en && resv_addr!=0 -> pending[resv_addr]<=1.
//  - Same-cycle write and reserve of same addr: data written AND pending stays 1 (new writer wins).
//  - Read: rNdata = (addr==0) ? 0 : (BYPASS && wena && waddr==addr) ? wdata : regFile[addr].
//    BYPASS=0: new value visible from next cycle.
//  - Busy: rNbusy = pending[addr], except BYPASS=1 and same-cycle write to addr -> 0.
//    Same-cycle reservation does not affect busy until the next cycle.
//  - Both read ports independent; same address on both returns identical data/busy.
//  - No arithmetic beyond idx increment (ADDR_WIDTH bits, stops at DEPTH-1, no wrap).
// STRUCTURE
//  - Shared package reg_file_pkg: state encodings (ST_INIT, ST_RUN), ZERO_REG address constant.
//  - Sub-module reg_file_scoreboard: DEPTH pending bits, set/clear/reset logic, two busy lookups.
//  - Top holds storage array, sweep FSM/idx counter, read muxes with bypass.
// TESTING
//  1 Reset sweep: preload r5=0xDEAD, pulse rst 1 cycle -> ready=0 for 15 cycles (DEPTH=16), then 1;
//    r5 reads 0.
//  2 Write/read: wena, waddr=3, wdata=0x1234 -> BYPASS=1: r0data=0x1234 same cycle; BYPASS=0:
//    old value same cycle, 0x1234 next cycle.
//  3 Zero reg: wena waddr=0 wdata=0xFFFF, resv_en resv_addr=0 -> r0addr=0 reads 0, r0busy=0 forever.
//  4 Scoreboard: resv 7 -> r1busy=1 next cycle; write r7=0x55 -> BYPASS=1: busy=0, data=0x55 same
//    cycle; pending clear next cycle.
//  5 Collision: resv 9 and write r9=0xAA same cycle -> r9 reads 0xAA, r9 busy=1 next cycle.
//  6 rst mid-sweep at cycle 5 -> ready stays 0 for 15 more cycles; wena during INIT has no effect.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared definitions for the pipeline register file: sweep FSM state encoding
// and the hardwired zero-register address.
package reg_file_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,   // post-reset clearing sweep in progress
        ST_RUN  = 1'b1    // normal operation, ops accepted
    } state_t;

    // Address of the register that always reads zero and is never stored.
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one bit per register. Decode sets a bit when it
// issues a writer, writeback clears it when the value lands. Two busy lookups
// serve the read ports.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] r0addr,
    input  logic [ADDR_WIDTH-1:0] r1addr,
    output logic                  r0busy,
    output logic                  r1busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(ZERO_REG);

    logic [DEPTH-1:0] pending;

    // Clear on write, set on reserve; set is applied last so a new writer
    // issued in the same cycle as an older writer's writeback keeps the bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (clr_en && clr_addr != ZERO) begin
                pending[clr_addr] <= 1'b0;
            end
            if (set_en && set_addr != ZERO) begin
                pending[set_addr] <= 1'b1;
            end
        end
    end

    // Busy lookup; with bypass, a writeback landing this cycle resolves the
    // hazard immediately because its data is forwarded to the reader.
    always_comb begin
        r0busy = pending[r0addr];
        r1busy = pending[r1addr];
        if (BYPASS != 0 && clr_en && clr_addr == r0addr) begin
            r0busy = 1'b0;
        end
        if (BYPASS != 0 && clr_en && clr_addr == r1addr) begin
            r1busy = 1'b0;
        end
        if (r0addr == ZERO) begin
            r0busy = 1'b0;
        end
        if (r1addr == ZERO) begin
            r1busy = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Pipeline register file with hardwired zero register, optional write-to-read
// bypass, pending-write scoreboard and a post-reset clearing sweep.
//
// ready is a level, not a per-transaction handshake: while ready=0 (reset or
// clearing sweep) every wena/resv_en is dropped and all read outputs are 0;
// while ready=1 every asserted wena/resv_en is taken on the rising edge with
// no back-pressure.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  wena,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  resv_en,
    input  logic [ADDR_WIDTH-1:0] resv_addr,
    input  logic [ADDR_WIDTH-1:0] r0addr,
    input  logic [ADDR_WIDTH-1:0] r1addr,
    output logic [DATA_WIDTH-1:0] r0data,
    output logic [DATA_WIDTH-1:0] r1data,
    output logic                  r0busy,
    output logic                  r1busy,
    output state_t                state_dbg
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(ZERO_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] regs [0:DEPTH-1];
    state_t                state;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  ready_q;
    logic                  wr_en;
    logic                  rs_en;
    logic                  sb_r0busy;
    logic                  sb_r1busy;

    // Sweep FSM: walk idx from 1 to DEPTH-1 clearing one register per cycle,
    // then enter RUN. idx saturates at the last register and never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_INIT;
            idx     <= ADDR_WIDTH'(1);
            ready_q <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (idx == LAST) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= ST_INIT;
                    idx     <= ADDR_WIDTH'(1);
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign state_dbg = state;

    // Ops are only accepted in RUN; register 0 is never a target.
    assign wr_en = ready_q && wena    && (waddr     != ZERO);
    assign rs_en = ready_q && resv_en && (resv_addr != ZERO);

    // Storage: the sweep owns the write port in INIT, writeback owns it in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                regs[idx] <= '0;
            end else if (wr_en) begin
                regs[waddr] <= wdata;
            end
        end
    end

    // Read muxes: zero register and not-ready force 0, then bypass, then array.
    always_comb begin
        r0data = '0;
        r1data = '0;
        if (ready_q && r0addr != ZERO) begin
            if (BYPASS != 0 && wr_en && waddr == r0addr) begin
                r0data = wdata;
            end else begin
                r0data = regs[r0addr];
            end
        end
        if (ready_q && r1addr != ZERO) begin
            if (BYPASS != 0 && wr_en && waddr == r1addr) begin
                r1data = wdata;
            end else begin
                r1data = regs[r1addr];
            end
        end
    end

    reg_file_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS     (BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (rs_en),
        .set_addr (resv_addr),
        .clr_en   (wr_en),
        .clr_addr (waddr),
        .r0addr   (r0addr),
        .r1addr   (r1addr),
        .r0busy   (sb_r0busy),
        .r1busy   (sb_r1busy)
    );

    // Pending bits are already clear throughout INIT; gating keeps the
    // not-ready contract explicit at the port.
    assign r0busy = ready_q && sb_r0busy;
    assign r1busy = ready_q && sb_r1busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus a randomized
// run, all checked against a behavioural model of the register file.
module tb_reg_file_sb;
    import reg_file_pkg::*;

    localparam int DW     = 64;
    localparam int AW     = 4;
    localparam int DEPTH  = 1 << AW;
    localparam int BYPASS = 1;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ready;
    logic          wena = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic          resv_en = 1'b0;
    logic [AW-1:0] resv_addr = '0;
    logic [AW-1:0] r0addr = '0;
    logic [AW-1:0] r1addr = '0;
    logic [DW-1:0] r0data;
    logic [DW-1:0] r1data;
    logic          r0busy;
    logic          r1busy;
    state_t        state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(BYPASS)) dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .wena      (wena),
        .waddr     (waddr),
        .wdata     (wdata),
        .resv_en   (resv_en),
        .resv_addr (resv_addr),
        .r0addr    (r0addr),
        .r1addr    (r1addr),
        .r0data    (r0data),
        .r1data    (r1data),
        .r0busy    (r0busy),
        .r1busy    (r1busy),
        .state_dbg (state_dbg)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] m_regs [DEPTH];
    bit            m_pend [DEPTH];
    bit            m_ready = 1'b0;
    int            m_left  = 0;
    logic [DW-1:0] exp_q [$];

    // Apply the inputs present at this rising edge to the model.
    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
            m_ready = 1'b0;
            m_left  = DEPTH - 1;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) m_ready = 1'b1;
        end else begin
            if (wena && waddr != 0) begin
                m_regs[waddr] = wdata;
                m_pend[waddr] = 1'b0;
            end
            if (resv_en && resv_addr != 0) m_pend[resv_addr] = 1'b1;
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (!m_ready || a == 0) return '0;
        if (BYPASS != 0 && wena && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (!m_ready || a == 0) return 1'b0;
        if (BYPASS != 0 && wena && waddr == a) return 1'b0;
        return m_pend[a];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        wena = 1'b0; waddr = '0; wdata = '0;
        resv_en = 1'b0; resv_addr = '0;
    endtask

    // Clock until ready rises, returning the number of edges taken (bounded).
    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        checks++; if (state_dbg !== ST_INIT) begin errors++; $display("FAIL reset_state got %0d want %0d", state_dbg, ST_INIT); end
        r0addr = 4'd3; r1addr = 4'd4;
        #1;
        checks++; if (r0data !== '0 || r1data !== '0 || r0busy !== 1'b0 || r1busy !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got %h %h %b %b want 0", r0data, r1data, r0busy, r1busy);
        end
        rst = 1'b0;
        wait_ready(n);
        checks++; if (n !== DEPTH - 1) begin errors++; $display("FAIL reset_sweep_len got %0d want %0d", n, DEPTH - 1); end
        checks++; if (state_dbg !== ST_RUN) begin errors++; $display("FAIL run_state got %0d want %0d", state_dbg, ST_RUN); end
    endtask

    task automatic test_reset_sweep();
        int n;
        wena = 1'b1; waddr = 4'd5; wdata = 64'hDEAD;
        tick();
        set_idle();
        r0addr = 4'd5;
        #1;
        checks++; if (r0data !== 64'hDEAD) begin errors++; $display("FAIL preload_r5 got %h want %h", r0data, 64'hDEAD); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready(n);
        checks++; if (n !== DEPTH - 1) begin errors++; $display("FAIL sweep_len got %0d want %0d", n, DEPTH - 1); end
        #1;
        checks++; if (r0data !== '0) begin errors++; $display("FAIL r5_cleared got %h want 0", r0data); end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] e;
        r0addr = 4'd3;
        wena = 1'b1; waddr = 4'd3; wdata = 64'h1234;
        #1;
        e = (BYPASS != 0) ? 64'h1234 : m_regs[3];
        checks++; if (r0data !== e) begin errors++; $display("FAIL wr_same_cycle got %h want %h", r0data, e); end
        tick();
        set_idle();
        #1;
        checks++; if (r0data !== 64'h1234) begin errors++; $display("FAIL wr_next_cycle got %h want %h", r0data, 64'h1234); end
    endtask

    task automatic test_zero_reg();
        wena = 1'b1; waddr = '0; wdata = 64'hFFFF;
        resv_en = 1'b1; resv_addr = '0;
        r0addr = '0; r1addr = '0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (r0data !== '0 || r1data !== '0) begin errors++; $display("FAIL zero_data got %h %h want 0", r0data, r1data); end
            checks++; if (r0busy !== 1'b0 || r1busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b %b want 0", r0busy, r1busy); end
            tick();
        end
        set_idle();
    endtask

    task automatic test_scoreboard();
        logic          eb;
        logic [DW-1:0] e;
        r1addr = 4'd7;
        resv_en = 1'b1; resv_addr = 4'd7;
        #1;
        checks++; if (r1busy !== 1'b0) begin errors++; $display("FAIL resv_same_cycle got %b want 0", r1busy); end
        tick();
        set_idle();
        #1;
        checks++; if (r1busy !== 1'b1) begin errors++; $display("FAIL resv_next_cycle got %b want 1", r1busy); end
        wena = 1'b1; waddr = 4'd7; wdata = 64'h55;
        #1;
        eb = (BYPASS != 0) ? 1'b0 : 1'b1;
        e  = (BYPASS != 0) ? 64'h55 : m_regs[7];
        checks++; if (r1busy !== eb) begin errors++; $display("FAIL wb_busy got %b want %b", r1busy, eb); end
        checks++; if (r1data !== e) begin errors++; $display("FAIL wb_data got %h want %h", r1data, e); end
        tick();
        set_idle();
        #1;
        checks++; if (r1busy !== 1'b0 || r1data !== 64'h55) begin
            errors++; $display("FAIL wb_settled got %b %h want 0 %h", r1busy, r1data, 64'h55);
        end
    endtask

    task automatic test_collision();
        r0addr = 4'd9; r1addr = 4'd9;
        wena = 1'b1; waddr = 4'd9; wdata = 64'hAA;
        resv_en = 1'b1; resv_addr = 4'd9;
        tick();
        set_idle();
        #1;
        checks++; if (r0data !== 64'hAA) begin errors++; $display("FAIL collide_data got %h want %h", r0data, 64'hAA); end
        checks++; if (r0busy !== 1'b1) begin errors++; $display("FAIL collide_busy got %b want 1", r0busy); end
        checks++; if (r1data !== r0data || r1busy !== r0busy) begin
            errors++; $display("FAIL dual_port_same got %h %b want %h %b", r1data, r1busy, 64'hAA, 1'b1);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_sweep_ready got %b want 0", ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wena = 1'b1; waddr = 4'd2; wdata = {$urandom, $urandom} | 64'h1;
        resv_en = 1'b1; resv_addr = 4'd2;
        wait_ready(n);
        checks++; if (n !== DEPTH - 1) begin errors++; $display("FAIL restart_len got %0d want %0d", n, DEPTH - 1); end
        set_idle();
        r0addr = 4'd2;
        #1;
        checks++; if (r0data !== '0 || r0busy !== 1'b0) begin
            errors++; $display("FAIL init_write_dropped got %h %b want 0 0", r0data, r0busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] v;
        for (int a = 1; a < DEPTH; a++) begin
            v = {$urandom, $urandom};
            wena = 1'b1; waddr = AW'(a); wdata = v;
            exp_q.push_back(v);
            tick();
        end
        set_idle();
        for (int a = 1; a < DEPTH; a++) begin
            r0addr = AW'(a); r1addr = AW'(DEPTH - a);
            #1;
            v = exp_q.pop_front();
            checks++; if (r0data !== v) begin errors++; $display("FAIL b2b_r%0d got %h want %h", a, r0data, v); end
            checks++; if (r1data !== m_regs[DEPTH - a]) begin errors++; $display("FAIL b2b_p1_r%0d got %h want %h", DEPTH - a, r1data, m_regs[DEPTH - a]); end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] e0, e1;
        logic          b0, b1;
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            wena      = $urandom_range(0, 1);
            waddr     = AW'($urandom_range(0, DEPTH - 1));
            wdata     = {$urandom, $urandom};
            resv_en   = $urandom_range(0, 1);
            resv_addr = AW'($urandom_range(0, DEPTH - 1));
            r0addr    = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1));
            r1addr    = ($urandom_range(0, 3) == 0) ? r0addr : AW'($urandom_range(0, DEPTH - 1));
            #1;
            e0 = exp_data(r0addr); e1 = exp_data(r1addr);
            b0 = exp_busy(r0addr); b1 = exp_busy(r1addr);
            checks++; if (ready !== m_ready) begin errors++; $display("FAIL rnd_ready c%0d got %b want %b", c, ready, m_ready); end
            checks++; if (r0data !== e0) begin errors++; $display("FAIL rnd_r0data c%0d got %h want %h", c, r0data, e0); end
            checks++; if (r1data !== e1) begin errors++; $display("FAIL rnd_r1data c%0d got %h want %h", c, r1data, e1); end
            checks++; if (r0busy !== b0) begin errors++; $display("FAIL rnd_r0busy c%0d got %b want %b", c, r0busy, b0); end
            checks++; if (r1busy !== b1) begin errors++; $display("FAIL rnd_r1busy c%0d got %b want %b", c, r1busy, b1); end
            tick();
        end
        rst = 1'b0;
        set_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_reset_sweep();
        test_write_read();
        test_zero_reg();
        test_scoreboard();
        test_collision();
        test_reset_mid_sweep();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
